// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: owner encoding and fairness default.
// Combinational content only; no latency, no flow control.
package dmem_port_arbiter_pkg;

  localparam int MAX_CPU_STREAK_DEF = 4;
  localparam int CONFLICT_W         = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  // Who owned last cycle's access and whether it was a read.
  typedef struct packed {
    owner_e who;
    logic   rd;
  } owner_t;

endpackage

// File: rtl/dmem_arb_fairness.sv
// Grant decision for CPU vs host with a bounded CPU streak while the host waits.
// Grants are combinational from reqs/mode/streak; losers hold req until granted.
module dmem_arb_fairness
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MAX_CPU_STREAK = MAX_CPU_STREAK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_running,
  input  logic cpu_req,
  input  logic host_req,
  output logic cpu_gnt,
  output logic host_gnt
);

  localparam int STREAK_W = $clog2(MAX_CPU_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                host_first;

  always_comb begin
    cpu_gnt    = 1'b0;
    host_gnt   = 1'b0;
    host_first = !cpu_running || (streak_q >= STREAK_MAX);
    if (!rst) begin
      if (cpu_req && host_req) begin
        host_gnt = host_first;
        cpu_gnt  = !host_first;
      end else begin
        cpu_gnt  = cpu_req;
        host_gnt = host_req;
      end
    end
  end

  // Streak only counts CPU wins that actually made the host wait.
  always_comb begin
    streak_d = streak_q;
    if (!host_req || host_gnt) begin
      streak_d = '0;
    end else if (cpu_gnt && (streak_q < STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU LSU and the AXI host path.
// One access per cycle, ack/rdata exactly one cycle after grant; losers hold req.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int MAX_CPU_STREAK = MAX_CPU_STREAK_DEF
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic                  cpu_running,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W/8-1:0]   cpu_wstrb,
  output logic                  cpu_gnt,
  output logic                  cpu_ack,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  input  logic [DATA_W/8-1:0]   host_wstrb,
  output logic                  host_gnt,
  output logic                  host_ack,
  output logic [DATA_W-1:0]     host_rdata,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [CONFLICT_W-1:0] conflict_cnt
);

  logic                  clk;
  logic                  rst;
  owner_t                own_q;
  owner_t                own_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [CONFLICT_W-1:0] conf_q;

  assign clk = S_AXI_ACLK;
  assign rst = S_AXI_ARESET;

  dmem_arb_fairness #(
    .MAX_CPU_STREAK(MAX_CPU_STREAK)
  ) u_fairness (
    .clk        (clk),
    .rst        (rst),
    .cpu_running(cpu_running),
    .cpu_req    (cpu_req),
    .host_req   (host_req),
    .cpu_gnt    (cpu_gnt),
    .host_gnt   (host_gnt)
  );

  // Address/data hold their last value when idle so the memory bus stays quiet.
  always_comb begin
    own_d     = '{who: OWN_NONE, rd: 1'b0};
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we ? cpu_wstrb : '0;
      own_d     = '{who: OWN_CPU, rd: !cpu_we};
    end else if (host_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we ? host_wstrb : '0;
      own_d     = '{who: OWN_HOST, rd: !host_we};
    end
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q   <= '{who: OWN_NONE, rd: 1'b0};
      addr_q  <= '0;
      wdata_q <= '0;
      conf_q  <= '0;
    end else begin
      own_q   <= own_d;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      if (cpu_req && host_req && (conf_q != {CONFLICT_W{1'b1}})) begin
        conf_q <= conf_q + 1'b1;
      end
    end
  end

  // Reset masks the return path so an access accepted just before it is never acked.
  assign cpu_ack      = !rst && (own_q.who == OWN_CPU);
  assign host_ack     = !rst && (own_q.who == OWN_HOST);
  assign cpu_rdata    = (cpu_ack && own_q.rd) ? mem_rdata : '0;
  assign host_rdata   = (host_ack && own_q.rd) ? mem_rdata : '0;
  assign conflict_cnt = rst ? '0 : conf_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: vector table, corner sequences, ack scoreboard.
module tb_dmem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_CPU  = 2'd1;
  localparam logic [1:0] G_HOST = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cpu_running;
  logic          cpu_req, cpu_we, host_req, host_we;
  logic [AW-1:0] cpu_addr, host_addr;
  logic [DW-1:0] cpu_wdata, host_wdata;
  logic [SW-1:0] cpu_wstrb, host_wstrb;
  logic          cpu_gnt, cpu_ack, host_gnt, host_ack, mem_en;
  logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata, mem_rdata;
  logic [SW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   conflict_cnt;

  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_dat;
  logic [DW-1:0] mem    [0:4095];
  logic [DW-1:0] shadow [0:4095];

  dmem_port_arbiter dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .cpu_running (cpu_running),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_gnt     (cpu_gnt),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_wstrb  (host_wstrb),
    .host_gnt    (host_gnt),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // Synchronous single-port memory model.
  always @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_dat;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < SW; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic          rst, run, creq, cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic [SW-1:0] cs;
    logic          hreq, hwe;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic [SW-1:0] hs;
    logic [1:0]    gnt;
  } vec_t;

  typedef struct {
    logic          c;
    logic          h;
    logic [DW-1:0] d;
  } ack_t;

  ack_t  sbq[$];
  vec_t  tbl[$];
  int    total = 0;
  int    bad = 0;
  int    exp_conf = 0;
  string tag = "";

  function automatic vec_t mk(input logic r, input logic run, input logic creq, input logic cwe,
                              input logic [AW-1:0] ca, input logic [DW-1:0] cd, input logic [SW-1:0] cs,
                              input logic hreq, input logic hwe, input logic [AW-1:0] ha,
                              input logic [DW-1:0] hd, input logic [SW-1:0] hs, input logic [1:0] g);
    vec_t v;
    v.rst = r;  v.run = run; v.creq = creq; v.cwe = cwe; v.ca = ca; v.cd = cd; v.cs = cs;
    v.hreq = hreq; v.hwe = hwe; v.ha = ha; v.hd = hd; v.hs = hs; v.gnt = g;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 12'h0, 32'h0, 4'h0, 0, 0, 12'h0, 32'h0, 4'h0, G_NONE);
  endfunction

  function automatic vec_t both(input logic r, input logic run, input logic [1:0] g);
    return mk(r, run, 1, 0, 12'h005, 32'h0, 4'h0, 1, 0, 12'h010, 32'h0, 4'h0, g);
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h at %0t", tag, nm, act, exp, $time);
    end
  endtask

  // Drive one cycle, check at the falling edge, then advance past the rising edge.
  task automatic step(input vec_t v);
    ack_t          e;
    ack_t          n;
    logic [SW-1:0] we_exp;
    logic [AW-1:0] a_exp;
    logic [DW-1:0] d_exp;
    rst = v.rst; cpu_running = v.run;
    cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.ca; cpu_wdata = v.cd; cpu_wstrb = v.cs;
    host_req = v.hreq; host_we = v.hwe; host_addr = v.ha; host_wdata = v.hd; host_wstrb = v.hs;
    @(negedge clk);
    e.c = 1'b0; e.h = 1'b0; e.d = '0;
    if (sbq.size() > 0) e = sbq.pop_front();
    if (v.rst) begin
      e.c = 1'b0; e.h = 1'b0; e.d = '0;
      sbq.delete();
    end
    chk("cpu_ack", 32'(cpu_ack), 32'(e.c));
    chk("host_ack", 32'(host_ack), 32'(e.h));
    chk("cpu_rdata", cpu_rdata, e.c ? e.d : 32'h0);
    chk("host_rdata", host_rdata, e.h ? e.d : 32'h0);
    chk("gnt", 32'({host_gnt, cpu_gnt}), 32'(v.gnt));
    we_exp = '0; a_exp = '0; d_exp = '0;
    if (v.gnt == G_CPU) begin
      a_exp = v.ca; d_exp = v.cd; we_exp = v.cwe ? v.cs : '0;
    end else if (v.gnt == G_HOST) begin
      a_exp = v.ha; d_exp = v.hd; we_exp = v.hwe ? v.hs : '0;
    end
    chk("mem_en", 32'(mem_en), 32'(v.gnt != G_NONE));
    chk("mem_we", 32'(mem_we), 32'(we_exp));
    if (v.gnt != G_NONE || v.rst) chk("mem_addr", 32'(mem_addr), 32'(a_exp));
    if (we_exp != '0) chk("mem_wdata", mem_wdata, d_exp);
    chk("conflict_cnt", 32'(conflict_cnt), v.rst ? 32'h0 : 32'(exp_conf));
    if (v.rst) exp_conf = 0;
    else if (v.creq && v.hreq && exp_conf < 65535) exp_conf++;
    if (v.gnt != G_NONE) begin
      n.c = (v.gnt == G_CPU);
      n.h = (v.gnt == G_HOST);
      n.d = (n.c ? v.cwe : v.hwe) ? 32'h0 : shadow[a_exp];
      sbq.push_back(n);
      for (int b = 0; b < SW; b++)
        if (we_exp[b]) shadow[a_exp][8*b +: 8] = d_exp[8*b +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] la [4];
    logic [DW-1:0] ld [4];
    la[0] = 12'h005; ld[0] = 32'hDEADBEEF;
    la[1] = 12'h010; ld[1] = 32'hAABBCCDD;
    la[2] = 12'h020; ld[2] = 32'h0BADF00D;
    la[3] = 12'h030; ld[3] = 32'h00000000;
    rst = 1'b1; cpu_running = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_wstrb = '0;
    load_en = 1'b0; load_addr = '0; load_dat = '0;
    for (int i = 0; i < 4; i++) begin
      shadow[la[i]] = ld[i];
      load_en = 1'b1; load_addr = la[i]; load_dat = ld[i];
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;

    // Directed vectors: reset, reads, writes, strobes, priority modes, back-to-back.
    tbl.push_back(both(1, 1, G_NONE));
    tbl.push_back(mk(0, 0, 0, 0, 12'h000, 32'h0, 4'h0, 1, 0, 12'h005, 32'h0, 4'h0, G_HOST));
    tbl.push_back(idle());
    tbl.push_back(mk(0, 1, 1, 1, 12'h010, 32'h11223344, 4'b0101, 0, 0, 12'h000, 32'h0, 4'h0, G_CPU));
    tbl.push_back(idle());
    tbl.push_back(mk(0, 1, 0, 0, 12'h000, 32'h0, 4'h0, 1, 0, 12'h010, 32'h0, 4'h0, G_HOST));
    tbl.push_back(mk(0, 0, 1, 0, 12'h020, 32'h0, 4'h0, 0, 0, 12'h000, 32'h0, 4'h0, G_CPU));
    tbl.push_back(mk(0, 0, 0, 0, 12'h000, 32'h0, 4'h0, 1, 1, 12'h020, 32'hFFFFFFFF, 4'h0, G_HOST));
    tbl.push_back(mk(0, 0, 0, 0, 12'h000, 32'h0, 4'h0, 1, 0, 12'h020, 32'h0, 4'h0, G_HOST));
    tbl.push_back(mk(0, 1, 1, 0, 12'h005, 32'h0, 4'h0, 1, 0, 12'h010, 32'h0, 4'h0, G_CPU));
    tbl.push_back(mk(0, 1, 1, 0, 12'h020, 32'h0, 4'h0, 0, 0, 12'h000, 32'h0, 4'h0, G_CPU));
    tbl.push_back(mk(0, 0, 1, 0, 12'h005, 32'h0, 4'h0, 1, 0, 12'h020, 32'h0, 4'h0, G_HOST));
    tbl.push_back(mk(0, 0, 1, 1, 12'h030, 32'h00000055, 4'hF, 1, 0, 12'h010, 32'h0, 4'h0, G_HOST));
    tbl.push_back(mk(0, 0, 1, 1, 12'h030, 32'h00000055, 4'hF, 0, 0, 12'h000, 32'h0, 4'h0, G_CPU));
    tbl.push_back(mk(0, 0, 0, 0, 12'h000, 32'h0, 4'h0, 1, 0, 12'h030, 32'h0, 4'h0, G_HOST));
    tbl.push_back(idle());
    for (int i = 0; i < tbl.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      step(tbl[i]);
    end
    chk("readback_strb", shadow[12'h010], 32'hAA22CC44);

    // CPU-priority fairness: four CPU wins then one host win, repeating.
    tag = "streak";
    step(both(1, 1, G_NONE));
    for (int i = 0; i < 12; i++) step(both(0, 1, (i % 5 == 4) ? G_HOST : G_CPU));
    step(idle());
    chk("conflict_12", 32'(conflict_cnt), 32'd12);

    // Halted CPU: host wins every contested cycle.
    tag = "halted";
    for (int i = 0; i < 6; i++) step(both(0, 0, G_HOST));

    // Reset right after a CPU grant drops the ack and clears the streak.
    tag = "rst_mid";
    step(both(1, 1, G_NONE));
    for (int i = 0; i < 3; i++) step(both(0, 1, G_CPU));
    step(both(1, 1, G_NONE));
    step(idle());
    for (int i = 0; i < 5; i++) step(both(0, 1, (i == 4) ? G_HOST : G_CPU));

    // Conflict counter saturation.
    tag = "sat";
    step(both(1, 1, G_NONE));
    rst = 1'b0; cpu_running = 1'b1; cpu_req = 1'b1; host_req = 1'b1; cpu_we = 1'b0; host_we = 1'b0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("conflict_fffe", 32'(conflict_cnt), 32'h0000FFFE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("conflict_ffff", 32'(conflict_cnt), 32'h0000FFFF);
    cpu_req = 1'b0; host_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("conflict_hold", 32'(conflict_cnt), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store unit and the AXI host path (the AXI slave's data-window reads and writes).
- Grants one access per cycle. Gives the CPU priority while it runs and the host priority while it is halted.
- Bounds host starvation with a streak counter. Returns a one-cycle-later acknowledge and read data to whichever requester owned the access.

Parameters:
- ADDR_W, 12, word address width of the data memory.
- DATA_W, 32, data width. Strobe width is DATA_W/8.
- MAX_CPU_STREAK, 4, maximum consecutive CPU grants while the host waits.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  synchronous reset, active-high.
- cpu_running  in  1  CPU is executing; selects the priority mode.
- cpu_req / cpu_we  in  1 / 1  CPU access request (level, held until granted) / write.
- cpu_addr / cpu_wdata / cpu_wstrb  in  ADDR_W / DATA_W / DATA_W/8  CPU access fields.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_ack  out  1  one-cycle pulse, cycle after the CPU grant.
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack on a read.
- host_req / host_we / host_addr / host_wdata / host_wstrb  in  same widths  host access fields.
- host_gnt / host_ack / host_rdata  out  1 / 1 / DATA_W  same meaning, host side.
- mem_en  out  1  memory port enable.
- mem_we  out  DATA_W/8  byte write enables.
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address and write data.
- mem_rdata  in  DATA_W  synchronous read data, one cycle after mem_en.
- conflict_cnt  out  16  saturating count of cycles with both requests asserted.

Behaviour:
- Reset values:
  - gnt, ack, rdata, mem_* and conflict_cnt are all 0.
  - Streak counter is 0. Owner register is NONE.
  - A pending ack at reset is dropped; no ack is issued after reset for an access accepted before it.
- Grants are combinational from the current req, cpu_running and streak count. The two grants are mutually exclusive (one-hot or zero).
- Arbitration:
  - Only one req asserted: grant it.
  - Both asserted, cpu_running=0: grant host.
  - Both asserted, cpu_running=1, streak<MAX_CPU_STREAK: grant CPU.
  - Both asserted, cpu_running=1, streak==MAX_CPU_STREAK: grant host.
- Streak counter:
  - +1 on a CPU grant while host_req=1.
  - Cleared on a host grant, or on any cycle with host_req=0.
  - Never exceeds MAX_CPU_STREAK.
- Memory drive in the grant cycle:
  - mem_en=1. mem_addr and mem_wdata come from the granted requester.
  - mem_we = wstrb if we=1, else 0.
  - No grant: mem_en=0 and mem_we=0. mem_addr/mem_wdata hold their last values; they are don't-care for verification.
- Owner register (NONE/CPU/HOST plus a read flag) is loaded each cycle from the grant.
- Next cycle:
  - The owner's ack pulses for exactly 1 cycle.
  - The owner's rdata = mem_rdata if the access was a read, else 0.
  - The non-owner's rdata = 0.
  - Latency is fixed: request accepted in cycle N, ack in cycle N+1.
- Back-to-back:
  - A requester holding req after a grant may be granted again in the next cycle (throughput of 1 access/cycle).
  - The ack of access N and the grant of access N+1 may coincide.
- A write with wstrb=0 is still granted and acked; memory is unchanged.
- cpu_running changing mid-stream takes effect in the same cycle's arbitration. The streak counter is not reset by that change.
- conflict_cnt: +1 on each cycle with cpu_req&host_req; saturates at 16'hFFFF.
- Address width: the upper bits of the AXI address are stripped by the AXI slave. This block does no range check.

Decomposition:
- Shared package holds the owner encoding (OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_HOST=2'd2) and the MAX_CPU_STREAK default.
- One natural sub-module: dmem_arb_fairness. It contains the streak counter and the grant decision: inputs are the reqs, cpu_running and the streak; outputs are the grants. The datapath mux and the ack/rdata return stay in the top.

Test Plan:
- Reset, then host-only read of addr 0x005 with mem model holding 0xDEADBEEF -> host_gnt in cycle 1, host_ack and host_rdata=0xDEADBEEF in cycle 2, cpu_ack=0.
- cpu_running=1, both reqs held for 12 cycles -> grant pattern CPU,CPU,CPU,CPU,HOST repeating; conflict_cnt=12.
- cpu_running=0, both reqs -> host granted every cycle; CPU never granted while host_req=1.
- CPU write addr 0x010, wdata 0x11223344, wstrb 4'b0101 -> mem_we=4'b0101 in the grant cycle, cpu_ack next cycle, cpu_rdata=0.
- CPU granted in cycle N, S_AXI_ARESET=1 in cycle N+1 -> no cpu_ack; all outputs 0; streak and conflict_cnt 0.
- 70000 conflict cycles -> conflict_cnt saturates at 0xFFFF.
